// File: rtl/jtag_host_shifter.sv
// JTAG host IR/DR scan shifter; `define JTAG_HOST_TLR_EN adds a 5x TMS=1 Test-Logic-Reset resync after TRST.
// Latency: rsp_valid L+5 (DR) / L+6 (IR) TCK after accept; cmd_ready only in IDLE, initiator holds cmd_valid.
module jtag_host_shifter #(
    parameter int DATA_MAX = 32
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic [5:0]          cmd_len,
    input  logic [DATA_MAX-1:0] cmd_data,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo,
    output logic                rsp_valid,
    output logic [DATA_MAX-1:0] rsp_data,
    output logic                busy
);

`ifdef JTAG_HOST_TLR_EN
    typedef enum logic [3:0] {IDLE, START, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, TLR} state_t;
    localparam state_t RST_STATE = TLR;
`else
    typedef enum logic [3:0] {IDLE, START, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    localparam logic [6:0] DMAX = 7'(DATA_MAX);

    state_t              state_q, state_d;
    logic                is_ir_q, is_ir_d;
    logic [5:0]          len_q, len_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DATA_MAX-1:0] data_q, data_d;
    logic [DATA_MAX-1:0] mask_q, mask_d;
    logic [DATA_MAX-1:0] rsp_q, rsp_d;
    logic                rsp_vld_q;
    logic [5:0]          len_c;
    logic                tms_c, tdi_c, last_bit;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q   <= RST_STATE;
            is_ir_q   <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            rsp_q     <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_ir_q   <= is_ir_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            rsp_q     <= rsp_d;
            rsp_vld_q <= (state_q == UPDATE);
        end
    end

    always_comb begin
        len_c = cmd_len;
        if (cmd_len == 6'd0)
            len_c = 6'd1;
        else if ({1'b0, cmd_len} > DMAX)
            len_c = DMAX[5:0];
    end

    assign last_bit = (cnt_q == len_q - 6'd1);

    always_comb begin
        state_d = state_q;
        is_ir_d = is_ir_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mask_d  = mask_q;
        rsp_d   = rsp_q;
        tms_c   = 1'b0;
        tdi_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = START;
                    is_ir_d = cmd_is_ir;
                    len_d   = len_c;
                    data_d  = cmd_data;
                    cnt_d   = '0;
                    mask_d  = DATA_MAX'(1);
                    rsp_d   = '0;
                end
            end
            START: begin
                tms_c   = 1'b1;
                state_d = SEL_DR;
            end
            SEL_DR: begin
                tms_c   = is_ir_q;
                state_d = is_ir_q ? SEL_IR : CAPTURE;
            end
            SEL_IR:  state_d = CAPTURE;
            CAPTURE: state_d = SHIFT;
            SHIFT: begin
                // mask_q is one-hot on the bit being shifted this cycle
                tms_c  = last_bit;
                tdi_c  = data_q[0];
                data_d = data_q >> 1;
                mask_d = mask_q << 1;
                rsp_d  = tdo ? (rsp_q | mask_q) : (rsp_q & ~mask_q);
                cnt_d  = cnt_q + 6'd1;
                if (last_bit)
                    state_d = EXIT1;
            end
            EXIT1: begin
                tms_c   = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: state_d = IDLE;
`ifdef JTAG_HOST_TLR_EN
            TLR: begin
                tms_c = (cnt_q < 6'd5);
                if (cnt_q == 6'd5) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // TRST gates the combinational outputs so they drop the moment reset asserts
    assign cmd_ready = TRST & (state_q == IDLE);
    assign busy      = TRST & (state_q != IDLE);
    assign tms       = TRST & tms_c;
    assign tdi       = TRST & tdi_c;
    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Randomized self-checking bench for jtag_host_shifter against a per-scan TAP sequence model.
module tb_jtag_host_shifter;
    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_ir = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        tms, tdi;
    logic        tdo = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rsp = '0;

    jtag_host_shifter #(.DATA_MAX(32)) dut (
        .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .tms(tms), .tdi(tdi), .tdo(tdo), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 TCK = ~TCK;

    task automatic release_and_sync();
        TRST = 1'b1;
        #1;
`ifdef JTAG_HOST_TLR_EN
        for (int j = 0; j < 6; j++) begin
            n_cmp++; if (tms !== (j < 5)) begin n_err++; $display("FAIL tlr_tms j=%0d got %b exp %b", j, tms, (j < 5)); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tlr_busy j=%0d got %b exp 1", j, busy); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL tlr_ready j=%0d got %b exp 0", j, cmd_ready); end
            @(negedge TCK);
        end
`endif
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %b exp 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_reset got %b exp 0", busy); end
        n_cmp++; if (tms !== 1'b0) begin n_err++; $display("FAIL tms_after_reset got %b exp 0", tms); end
    endtask

    // One complete scan: accept at the next posedge, then check every cycle against
    // the TAP walk derived from the command. mode 1 pulses a junk command while busy,
    // mode 2 presents the next command from cycle 1 and leaves it held.
    task automatic scan(input bit ir, input int len_raw, input logic [31:0] data,
                        input logic [31:0] pat, input int mode, input bit n_ir,
                        input int n_len, input logic [31:0] n_data, input int abort_k);
        int          L, pre, T;
        bit          etms[$];
        bit          etdi[$];
        logic [63:0] m;
        logic [31:0] erd;
        L   = (len_raw == 0) ? 1 : ((len_raw > 32) ? 32 : len_raw);
        pre = ir ? 4 : 3;
        etms.push_back(1'b1);
        etms.push_back(ir);
        if (ir) etms.push_back(1'b0);
        etms.push_back(1'b0);
        repeat (pre) etdi.push_back(1'b0);
        for (int i = 0; i < L; i++) begin
            etms.push_back(i == L - 1);
            etdi.push_back(data[i]);
        end
        etms.push_back(1'b1); etms.push_back(1'b0);
        etdi.push_back(1'b0); etdi.push_back(1'b0);
        T   = pre + L + 2;
        m   = (64'd1 << L) - 64'd1;
        erd = pat & m[31:0];

        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready got %b exp 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_is_ir = ir; cmd_len = len_raw[5:0]; cmd_data = data;
        @(posedge TCK);
        @(negedge TCK);
        cmd_valid = 1'b0;
        for (int k = 0; k < T; k++) begin
            n_cmp++; if (tms !== etms[k]) begin n_err++; $display("FAIL tms k=%0d got %b exp %b", k, tms, etms[k]); end
            n_cmp++; if (tdi !== etdi[k]) begin n_err++; $display("FAIL tdi k=%0d got %b exp %b", k, tdi, etdi[k]); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy k=%0d got %b exp 1", k, busy); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL ready_busy k=%0d got %b exp 0", k, cmd_ready); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL early_rsp k=%0d got %b exp 0", k, rsp_valid); end
            if (k == abort_k) begin
                TRST = 1'b0; cmd_valid = 1'b0;
                #1;
                n_cmp++; if ({tms, tdi, busy, rsp_valid, cmd_ready} !== 5'b0) begin n_err++; $display("FAIL abort_outs got %b exp 00000", {tms, tdi, busy, rsp_valid, cmd_ready}); end
                n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL abort_rsp_data got %h exp 0", rsp_data); end
                repeat (2) begin
                    @(negedge TCK);
                    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_hold got vld=%b busy=%b exp 0 0", rsp_valid, busy); end
                end
                release_and_sync();
                last_rsp = '0;
                return;
            end
            tdo = (k >= pre && k < pre + L) ? pat[k - pre] : 1'($urandom);
            if (mode == 1 && k == 1) begin
                cmd_valid = 1'b1; cmd_is_ir = 1'($urandom); cmd_len = 6'($urandom); cmd_data = $urandom;
            end
            if (mode == 1 && k == 3) cmd_valid = 1'b0;
            if (mode == 2 && k == 1) begin
                cmd_valid = 1'b1; cmd_is_ir = n_ir; cmd_len = n_len[5:0]; cmd_data = n_data;
            end
            @(negedge TCK);
        end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rsp_valid at L+%0d got %b exp 1", T - L, rsp_valid); end
        n_cmp++; if (rsp_data !== erd) begin n_err++; $display("FAIL rsp_data got %h exp %h", rsp_data, erd); end
        n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL rsp_idle got busy=%b rdy=%b exp 0 1", busy, cmd_ready); end
        n_cmp++; if (tms !== 1'b0 || tdi !== 1'b0) begin n_err++; $display("FAIL rsp_pins got tms=%b tdi=%b exp 0 0", tms, tdi); end
        last_rsp = erd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge TCK);
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_pulse_width got %b exp 0", rsp_valid); end
            n_cmp++; if (rsp_data !== last_rsp) begin n_err++; $display("FAIL rsp_hold got %h exp %h", rsp_data, last_rsp); end
            n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || tms !== 1'b0 || tdi !== 1'b0) begin
                n_err++; $display("FAIL idle_pins got busy=%b rdy=%b tms=%b tdi=%b exp 0 1 0 0", busy, cmd_ready, tms, tdi);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge TCK);
        n_cmp++; if ({tms, tdi, rsp_valid, busy} !== 4'b0) begin n_err++; $display("FAIL reset_outs got %b exp 0000", {tms, tdi, rsp_valid, busy}); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        @(negedge TCK);
        release_and_sync();
    endtask

    task automatic test_dr();
        scan(1'b0, 8, 32'hA5, 32'h3C, 0, 1'b0, 0, 32'h0, -1);
        idle(2);
    endtask

    task automatic test_ir();
        scan(1'b1, 5, 32'h1F, $urandom, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
    endtask

    task automatic test_len_bounds();
        scan(1'b0, 0, $urandom, $urandom, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
        scan(1'b0, 40, $urandom, $urandom, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
        scan(1'b1, 32, $urandom, $urandom, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
    endtask

    task automatic test_ignore_busy();
        scan(1'b0, 12, $urandom, $urandom, 1, 1'b0, 0, 32'h0, -1);
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d2;
        d2 = $urandom;
        scan(1'b0, 8, $urandom, $urandom, 2, 1'b1, 6, d2, -1);
        scan(1'b1, 6, d2, $urandom, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
    endtask

    task automatic test_abort();
        scan(1'b0, 8, 32'hFF, $urandom, 0, 1'b0, 0, 32'h0, 5);
        scan(1'b0, 8, 32'hA5, 32'h3C, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
    endtask

    task automatic test_random();
        bit          c_ir, n_ir, b2b;
        int          c_len, n_len, mode;
        logic [31:0] c_dat, n_dat;
        c_ir = 1'($urandom); c_len = $urandom_range(0, 63); c_dat = $urandom;
        for (int it = 0; it < 25; it++) begin
            n_ir  = 1'($urandom); n_len = $urandom_range(0, 63); n_dat = $urandom;
            b2b   = 1'($urandom);
            mode  = b2b ? 2 : int'($urandom_range(0, 1));
            scan(c_ir, c_len, c_dat, $urandom, mode, n_ir, n_len, n_dat, -1);
            if (!b2b) idle($urandom_range(1, 3));
            c_ir = n_ir; c_len = n_len; c_dat = n_dat;
        end
        scan(c_ir, c_len, c_dat, $urandom, 0, 1'b0, 0, 32'h0, -1);
        idle(1);
    endtask

    initial begin
        test_reset();
        test_dr();
        test_ir();
        test_len_bounds();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jtag_host_shifter.md
JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

Interface
REQ-001 SHALL have parameter DATA_MAX, default 32, meaning the maximum shift length in bits and the width of cmd_data/rsp_data.
REQ-002 SHALL have ports:
- TCK  input  1  sole clock; all state changes on rising edge.
- TRST  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_len  input  6  scan length in bits.
- cmd_data  input  DATA_MAX  bits to shift out, LSB first.
- tms  output  1  TMS driven to the target TAP.
- tdi  output  1  TDI driven to the target TAP.
- tdo  input  1  TDO from the target TAP.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid.
- rsp_data  output  DATA_MAX  bits captured from tdo, LSB first.
- busy  output  1  a scan is in progress.

Function
REQ-003 SHALL implement the host states IDLE, START, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE; each state equals the target TAP state during that cycle (START = Run-Test/Idle).
REQ-004 SHALL drive cmd_ready=1 only in IDLE.
REQ-005 SHALL latch cmd_is_ir, the length and cmd_data, then go to START, on a TCK edge with cmd_valid&&cmd_ready.
REQ-006 SHALL drive tms combinationally per state: IDLE 0, START 1, SEL_DR = latched is_ir, SEL_IR 0, CAPTURE 0, SHIFT 1 only on the last bit (else 0), EXIT1 1, UPDATE 0.
REQ-007 SHALL follow the transitions START->SEL_DR; SEL_DR->SEL_IR when is_ir, else ->CAPTURE; SEL_IR->CAPTURE; CAPTURE->SHIFT; SHIFT->EXIT1 after the last bit; EXIT1->UPDATE; UPDATE->IDLE.
REQ-008 SHALL, in SHIFT cycle i (i=0..len-1), drive tdi=latched data[i] and sample tdo at that cycle's closing edge into rsp_data[i].
REQ-009 SHALL drive tdi=0 outside SHIFT.
REQ-010 SHALL clear rsp_data bits i>=len at command acceptance.
REQ-011 SHALL coerce cmd_len: 0 -> 1; values greater than DATA_MAX -> DATA_MAX.
REQ-012 SHALL pulse rsp_valid for exactly the first IDLE cycle after UPDATE.
REQ-013 SHALL hold rsp_data stable until the next command is accepted.
REQ-014 SHALL assert rsp_valid, with its data, L+5 cycles after the accepting edge for a DR scan and L+6 cycles for an IR scan (L = coerced length).
REQ-015 SHALL accept a new command in the rsp_valid cycle if cmd_valid is high (back-to-back); that cycle's rsp_data belongs to the previous command.
REQ-016 SHALL drive busy = (state != IDLE).
REQ-017 SHALL ignore cmd_valid while busy; the command is not latched and not lost, and the initiator holds it until cmd_ready.

Reset
REQ-018 SHALL, while TRST=0, force: state IDLE (or TLR, see REQ-021), tms=0, tdi=0, rsp_valid=0, rsp_data=0, busy=0, shift counter 0, and latched command cleared.
REQ-019 SHALL abort any in-flight scan on TRST assertion with no rsp_valid for that scan; TRST deassertion is synchronised by the instantiator.

Configuration
REQ-020 SHALL provide the macro JTAG_HOST_TLR_EN to compile the Test-Logic-Reset resync sequence in or out.
REQ-021 With JTAG_HOST_TLR_EN defined:
- reset enters state TLR, and busy=1 in TLR;
- TLR drives tms=1 for 5 cycles, then tms=0 for 1 cycle, then goes to IDLE;
- cmd_ready first rises 6 cycles after TRST deasserts.
REQ-022 Without JTAG_HOST_TLR_EN: state TLR does not exist, and cmd_ready=1 in the first cycle after TRST deasserts.

Verification
REQ-023 DR scan, cmd_len=8, cmd_data=0xA5, tdo fed 0x3C LSB first -> tms sequence 1,0,0,0000000 then 1,1,0; tdi=1,0,1,0,0,1,0,1 in SHIFT; rsp_valid 13 cycles after accept; rsp_data=0x3C.
REQ-024 IR scan, cmd_len=5, cmd_data=0x1F -> tms 1,1,0,0,0000,1,1,0; tdi all 1 in SHIFT; rsp_valid 11 cycles after accept.
REQ-025 cmd_len=0 gives a 1-bit shift (SHIFT tms=1 immediately); cmd_len=40 with DATA_MAX=32 gives exactly 32 SHIFT cycles.
REQ-026 Back-to-back: second command held valid during the first scan -> accepted in the first command's rsp_valid cycle; first rsp_data intact in that cycle.
REQ-027 TRST pulsed low in the 3rd SHIFT cycle -> all outputs 0 immediately, no rsp_valid; next command completes normally (with TLR_EN: 5x tms=1, then tms=0, first).
REQ-028 cmd_valid pulsed while busy -> ignored; the state sequence is unchanged.
